mw_add_seq: RTL

MW_ADD_SEQ -- requirements
Module: mw_add_seq

---
 rtl/mw_add_seq_if.sv | 35 +++
 rtl/mw_add_seq.sv | 135 +++++++++++++
 2 files changed

// File: rtl/mw_add_seq_if.sv
// Beat-stream bundle for the multi-word sequential adder (operand beats in, sum beats out).
// Latency: none, wiring only.
// Backpressure: in_ready/out_ready carry the valid-ready handshake on each side.
// Ports: in_* operand beat channel, out_* sum beat channel, err sticky protocol flag.
// Modports: master = upstream/downstream environment, slave = the adder.
interface mw_add_seq_if #(
    parameter int N     = 8,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_a;
    logic [N-1:0]     in_b;
    logic             in_carry;
    logic             in_first;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out_sum;
    logic             out_last;
    logic             out_carry;
    logic             out_ovf;
    logic [CNT_W-1:0] out_beats;
    logic             err;

    modport master (
        output in_valid, in_a, in_b, in_carry, in_first, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_last, out_carry, out_ovf, out_beats, err
    );

    modport slave (
        input  in_valid, in_a, in_b, in_carry, in_first, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_last, out_carry, out_ovf, out_beats, err
    );
endinterface

// File: rtl/mw_add_seq.sv
// Multi-word adder: adds packets of N-bit words LS word first, carrying between beats.
// Latency: one cycle, beat accepted at edge k is presented on out_* after edge k.
// Backpressure: single output register, in_ready = !out_valid || out_ready (bubble-free).
// Ports: clk, rst_n (async active-low), bus (mw_add_seq_if.slave: in_* beats, out_* sums, err).
// Optional: define MW_ADD_OVF_EN to produce signed overflow on out_ovf for last beats;
// without it out_ovf is tied to 0 and no overflow logic exists.
module mw_add_seq #(
    parameter int N     = 8,
    parameter int CNT_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    mw_add_seq_if.slave bus
);
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [N-1:0]     out_sum_q, out_sum_d;
    logic             out_last_q, out_last_d;
    logic             out_carry_q, out_carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             err_q, err_d;

    logic             in_hs;
    logic             out_hs;
    logic             is_first;
    logic             err_set;
    logic             cin;
    logic [N:0]       sum_full;

    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign in_hs        = bus.in_valid && bus.in_ready;
    assign out_hs       = out_valid_q && bus.out_ready;

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM: next state; any accepted beat closes the packet when it carries in_last
    always_comb begin
        state_d = state_q;
        if (in_hs) state_d = bus.in_last ? IDLE : BUSY;
    end

    // FSM: decode. In IDLE every beat starts a packet; in BUSY an in_first restarts it.
    // Both a missing start marker and an unexpected one are protocol errors.
    always_comb begin
        is_first = (state_q == IDLE) || bus.in_first;
        err_set  = in_hs && ((state_q == IDLE) ? !bus.in_first : bus.in_first);
    end

    // Word add with carry chained through carry_q across beats
    always_comb begin
        cin      = is_first ? bus.in_carry : carry_q;
        sum_full = {1'b0, bus.in_a} + {1'b0, bus.in_b} + {{N{1'b0}}, cin};
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_last_d  = out_last_q;
        out_carry_d = out_carry_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        err_d       = err_q | err_set;
        if (in_hs) begin
            // A new beat overwrites the register even if the old one is leaving now
            out_valid_d = 1'b1;
            out_sum_d   = sum_full[N-1:0];
            out_carry_d = sum_full[N];
            out_last_d  = bus.in_last;
            carry_d     = sum_full[N];
            if (is_first)             cnt_d = CNT_ONE;
            else if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
        end else if (out_hs) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_last_q  <= 1'b0;
            out_carry_q <= 1'b0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_last_q  <= out_last_d;
            out_carry_q <= out_carry_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            err_q       <= err_d;
        end
    end

`ifdef MW_ADD_OVF_EN
    logic out_ovf_q, out_ovf_d;

    // Signed overflow of the whole packet shows up only in the top (last) word
    always_comb begin
        out_ovf_d = out_ovf_q;
        if (in_hs) begin
            out_ovf_d = bus.in_last && (bus.in_a[N-1] == bus.in_b[N-1]) &&
                        (sum_full[N-1] != bus.in_a[N-1]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) out_ovf_q <= 1'b0;
        else        out_ovf_q <= out_ovf_d;
    end

    assign bus.out_ovf = out_ovf_q;
`else
    assign bus.out_ovf = 1'b0;
`endif

    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_carry = out_carry_q;
    assign bus.out_beats = cnt_q;
    assign bus.err       = err_q;
endmodule
